// File: rtl/mov_pkg.sv
// Shared definitions for the bit-serial MOV path (transmit and receive ends).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mov_pkg;

    // Receive-side frame state.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } mov_state_t;

    localparam int MOV_WIDTH_DEFAULT = 8;

    // Frames travel LSB first; the transmit-side mover relies on the same order.
    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/mov_shift_in.sv
// Indexed-write shift register that collects one frame bit by bit.
// Latency: a write lands on the next clk edge; o_next shows the post-write word combinationally.
// Backpressure: none; writes happen whenever the parent commands them.
//
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset (clears the register)
//   i_start    - clear the register and place i_bit in bit 0
//   i_wr       - write i_bit into bit i_idx
//   i_idx      - bit position for i_wr / o_next
//   i_bit      - incoming serial bit
//   o_next     - stored word with bit i_idx replaced by i_bit
module mov_shift_in #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (i_start) begin
            // Fresh frame: drop any stale bits from an abandoned frame.
            r_q <= {{(WIDTH-1){1'b0}}, i_bit};
        end else if (i_wr) begin
            r_q[i_idx] <= i_bit;
        end
    end

    // Lets the parent capture the completed word in the same cycle the
    // final bit arrives, without waiting for it to land in r_q.
    always_comb begin
        w_next         = r_q;
        w_next[i_idx]  = i_bit;
    end

    assign o_next = w_next;

endmodule

// File: rtl/mov_serial_rx.sv
// Reassembles an LSB-first serial MOV frame into a parallel word for the ALU operand stage.
// Latency: word valid on out_data/out_valid one cycle after its final bit is accepted.
// Backpressure: only the final bit stalls (ser_ready=0) while the one-word buffer is full and not being taken.
//
// Ports:
//   clk, rstn             - clock, asynchronous active-low reset
//   ser_valid/ser_ready   - serial bit handshake; ser_start marks bit 0; ser_bit is the data
//   out_data/out_valid    - buffered parallel word and its valid flag
//   out_ready             - consumer takes out_data this cycle
//   frame_err             - one-cycle pulse after a stray bit or a mid-frame restart
//   busy                  - a frame is partially received
module mov_serial_rx
    import mov_pkg::*;
#(
    parameter int WIDTH = MOV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ser_valid,
    output logic             ser_ready,
    input  logic             ser_start,
    input  logic             ser_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             busy
);

    mov_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_frame_err;

    logic             w_last;
    logic             w_accept;
    logic             w_done;
    logic             w_sh_start;
    logic             w_sh_wr;
    logic [WIDTH-1:0] w_next_word;

    assign w_last     = (r_state == SHIFT) && (r_count == CNT_W'(WIDTH - 1));
    // Earlier bits never stall: they only touch the shift register, and the
    // final bit is the only one that needs a free output buffer.
    assign ser_ready  = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = ser_valid && ser_ready;
    assign w_done     = w_accept && !ser_start && w_last;

    assign w_sh_start = w_accept && ser_start;
    assign w_sh_wr    = w_accept && !ser_start && (r_state == SHIFT);

    mov_shift_in #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_in (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (w_sh_start),
        .i_wr    (w_sh_wr),
        .i_idx   (r_count),
        .i_bit   (ser_bit),
        .o_next  (w_next_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            // Consumption first; a same-cycle completion overrides it so the
            // buffer refills with no bubble.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_done) begin
                r_out_data  <= w_next_word;
                r_out_valid <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (ser_start) begin
                            r_count <= CNT_W'(1);
                            r_state <= SHIFT;
                        end else begin
                            // Bit without a frame start: drop it.
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (w_accept) begin
                        if (ser_start) begin
                            // Restart abandons the partial word, even on the final-bit slot.
                            r_frame_err <= 1'b1;
                            r_count     <= CNT_W'(1);
                        end else if (w_last) begin
                            r_count <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == SHIFT);

endmodule
